// File: rtl/conv_dispatch.sv
// Issue queue feeding custom-0 convolution instructions to conv_unit, one in flight at a time.
// Optional same-cycle issue into an idle unit when CONV_DISPATCH_BYPASS_EN is defined.
module conv_dispatch #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        opcode_valid_i,
  input  logic [31:0] opcode_opcode_i,
  input  logic [31:0] opcode_pc_i,
  input  logic        opcode_invalid_i,
  input  logic [4:0]  opcode_rd_idx_i,
  input  logic [4:0]  opcode_ra_idx_i,
  input  logic [4:0]  opcode_rb_idx_i,
  input  logic [31:0] opcode_ra_operand_i,
  input  logic [31:0] opcode_rb_operand_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [31:0] conv_opcode_o,
  output logic [31:0] conv_pc_o,
  output logic        conv_invalid_o,
  output logic [4:0]  conv_rd_idx_o,
  output logic [4:0]  conv_ra_idx_o,
  output logic [4:0]  conv_rb_idx_o,
  output logic [31:0] conv_ra_operand_o,
  output logic [31:0] conv_rb_operand_o,
  input  logic        conv_busy_i,
  input  logic        conv_valid_i,
  input  logic [31:0] conv_writeback_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_idx_o,
  output logic [31:0] wb_value_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [31:0] opcode;
    logic [31:0] pc;
    logic [4:0]  rd_idx;
    logic [4:0]  ra_idx;
    logic [4:0]  rb_idx;
    logic [31:0] ra_operand;
    logic [31:0] rb_operand;
  } entry_t;

  localparam entry_t IDLE_ENTRY = '{opcode: 32'h0000_0013, default: '0};

  entry_t          mem [DEPTH];
  entry_t          incoming;
  entry_t          head;
  entry_t          conv_q;
  entry_t          conv_sel;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   count;
  logic            in_flight;
  logic [4:0]      inflight_rd;
  logic            push_ok;
  logic            push;
  logic            dispatch;
  logic            bypass;

  assign incoming = '{
    opcode:     opcode_opcode_i,
    pc:         opcode_pc_i,
    rd_idx:     opcode_rd_idx_i,
    ra_idx:     opcode_ra_idx_i,
    rb_idx:     opcode_rb_idx_i,
    ra_operand: opcode_ra_operand_i,
    rb_operand: opcode_rb_operand_i
  };

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count   = wr_ptr - rd_ptr;
  assign stall_o = (count == PW'(DEPTH));
  assign head    = mem[rd_ptr[AW-1:0]];

  // Flush wins over a same-cycle offer.
  assign push_ok = opcode_valid_i & ~stall_o & ~opcode_invalid_i &
                   (opcode_opcode_i[6:0] == 7'h0B) & ~flush_i;

  // Uses registered in_flight, so a completing result never lets a dispatch through that cycle.
  assign dispatch = (count != '0) & ~in_flight & ~conv_busy_i;

`ifdef CONV_DISPATCH_BYPASS_EN
  assign bypass   = push_ok & (count == '0) & ~in_flight & ~conv_busy_i;
  assign conv_sel = bypass ? incoming : conv_q;
`else
  assign bypass   = 1'b0;
  assign conv_sel = conv_q;
`endif

  assign push = push_ok & ~bypass;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= incoming;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      in_flight   <= 1'b0;
      inflight_rd <= '0;
      conv_q      <= IDLE_ENTRY;
      wb_valid_o  <= 1'b0;
      wb_rd_idx_o <= '0;
      wb_value_o  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      if (flush_i) begin
        rd_ptr <= wr_ptr;
      end else if (dispatch) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      conv_q <= dispatch ? head : IDLE_ENTRY;

      if (dispatch || bypass) begin
        in_flight   <= 1'b1;
        inflight_rd <= bypass ? incoming.rd_idx : head.rd_idx;
      end else if (conv_valid_i) begin
        in_flight <= 1'b0;
      end

      // A result with nothing in flight is stray and never reaches writeback.
      wb_valid_o  <= conv_valid_i & in_flight;
      wb_rd_idx_o <= inflight_rd;
      wb_value_o  <= conv_writeback_i;
    end
  end

  assign conv_opcode_o     = conv_sel.opcode;
  assign conv_pc_o         = conv_sel.pc;
  assign conv_invalid_o    = 1'b0;
  assign conv_rd_idx_o     = conv_sel.rd_idx;
  assign conv_ra_idx_o     = conv_sel.ra_idx;
  assign conv_rb_idx_o     = conv_sel.rb_idx;
  assign conv_ra_operand_o = conv_sel.ra_operand;
  assign conv_rb_operand_o = conv_sel.rb_operand;

endmodule

// File: tb/tb_conv_dispatch.sv
// Directed bench for conv_dispatch: queue-level reference model compared every cycle,
// plus literal expectations on key events. Honours CONV_DISPATCH_BYPASS_EN if defined.
module tb_conv_dispatch;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        opcode_valid_i;
  logic [31:0] opcode_opcode_i;
  logic [31:0] opcode_pc_i;
  logic        opcode_invalid_i;
  logic [4:0]  opcode_rd_idx_i;
  logic [4:0]  opcode_ra_idx_i;
  logic [4:0]  opcode_rb_idx_i;
  logic [31:0] opcode_ra_operand_i;
  logic [31:0] opcode_rb_operand_i;
  logic        flush_i;
  logic        stall_o;
  logic [31:0] conv_opcode_o;
  logic [31:0] conv_pc_o;
  logic        conv_invalid_o;
  logic [4:0]  conv_rd_idx_o;
  logic [4:0]  conv_ra_idx_o;
  logic [4:0]  conv_rb_idx_o;
  logic [31:0] conv_ra_operand_o;
  logic [31:0] conv_rb_operand_o;
  logic        conv_busy_i;
  logic        conv_valid_i;
  logic [31:0] conv_writeback_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_idx_o;
  logic [31:0] wb_value_o;

  always #5 clk = ~clk;

  conv_dispatch #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .opcode_valid_i(opcode_valid_i), .opcode_opcode_i(opcode_opcode_i),
    .opcode_pc_i(opcode_pc_i), .opcode_invalid_i(opcode_invalid_i),
    .opcode_rd_idx_i(opcode_rd_idx_i), .opcode_ra_idx_i(opcode_ra_idx_i),
    .opcode_rb_idx_i(opcode_rb_idx_i), .opcode_ra_operand_i(opcode_ra_operand_i),
    .opcode_rb_operand_i(opcode_rb_operand_i), .flush_i(flush_i),
    .stall_o(stall_o), .conv_opcode_o(conv_opcode_o), .conv_pc_o(conv_pc_o),
    .conv_invalid_o(conv_invalid_o), .conv_rd_idx_o(conv_rd_idx_o),
    .conv_ra_idx_o(conv_ra_idx_o), .conv_rb_idx_o(conv_rb_idx_o),
    .conv_ra_operand_o(conv_ra_operand_o), .conv_rb_operand_o(conv_rb_operand_o),
    .conv_busy_i(conv_busy_i), .conv_valid_i(conv_valid_i),
    .conv_writeback_i(conv_writeback_i), .wb_valid_o(wb_valid_o),
    .wb_rd_idx_o(wb_rd_idx_o), .wb_value_o(wb_value_o)
  );

  typedef struct packed {
    logic [31:0] op;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] a;
    logic [31:0] b;
  } ent_t;

  ent_t        exp_q[$];
  bit          m_started = 0;
  bit          m_inflight;
  logic [4:0]  m_rd;
  bit          m_show;
  ent_t        m_cur;
  logic        m_wbv;
  logic [4:0]  m_wbrd;
  logic [31:0] m_wbval;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t offered();
    return '{op: opcode_opcode_i, pc: opcode_pc_i, rd: opcode_rd_idx_i,
             ra: opcode_ra_idx_i, rb: opcode_rb_idx_i,
             a: opcode_ra_operand_i, b: opcode_rb_operand_i};
  endfunction

  function automatic bit acceptable();
    return opcode_valid_i && !opcode_invalid_i && opcode_opcode_i[6:0] == 7'h0B &&
           exp_q.size() < DEPTH && !flush_i;
  endfunction

  function automatic bit goes_direct();
`ifdef CONV_DISPATCH_BYPASS_EN
    return acceptable() && exp_q.size() == 0 && !m_inflight && !conv_busy_i;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: advances one cycle on each edge from the inputs it sees.
  always @(posedge clk) begin
    m_started = 1;
    if (rst_i) begin
      exp_q.delete();
      m_inflight = 0; m_rd = '0; m_show = 0;
      m_wbv = 0; m_wbrd = '0; m_wbval = '0;
    end else begin
      bit direct, issue, accept;
      direct = goes_direct();
      accept = acceptable() && !direct;
      issue  = exp_q.size() != 0 && !m_inflight && !conv_busy_i;
      m_wbv   = conv_valid_i && m_inflight;
      m_wbrd  = m_rd;
      m_wbval = conv_writeback_i;
      m_show  = issue;
      if (issue) begin
        m_cur = exp_q.pop_front();
        m_inflight = 1; m_rd = m_cur.rd;
      end else if (direct) begin
        m_inflight = 1; m_rd = opcode_rd_idx_i;
      end else if (conv_valid_i) begin
        m_inflight = 0;
      end
      if (flush_i) exp_q.delete();
      else if (accept) exp_q.push_back(offered());
    end
  end

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin
    if (m_started) begin
      ent_t e;
      e = '{op: NOP, default: '0};
      if (m_show) e = m_cur;
      else if (!rst_i && goes_direct()) e = offered();
      chk("stall", stall_o, exp_q.size() == DEPTH);
      chk("conv_opcode", conv_opcode_o, e.op);
      chk("conv_pc", conv_pc_o, e.pc);
      chk("conv_invalid", conv_invalid_o, 0);
      chk("conv_rd", conv_rd_idx_o, e.rd);
      chk("conv_ra", conv_ra_idx_o, e.ra);
      chk("conv_rb", conv_rb_idx_o, e.rb);
      chk("conv_a", conv_ra_operand_o, e.a);
      chk("conv_b", conv_rb_operand_o, e.b);
      chk("wb_valid", wb_valid_o, m_wbv);
      chk("wb_rd", wb_rd_idx_o, m_wbrd);
      chk("wb_value", wb_value_o, m_wbval);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_offer(input logic [31:0] op, input logic [4:0] rd, input logic inv);
    opcode_valid_i      = 1'b1;
    opcode_opcode_i     = op;
    opcode_pc_i         = 32'h0000_0400 + {25'd0, rd, 2'b00};
    opcode_invalid_i    = inv;
    opcode_rd_idx_i     = rd;
    opcode_ra_idx_i     = rd + 5'd1;
    opcode_rb_idx_i     = rd + 5'd2;
    opcode_ra_operand_i = op ^ 32'hA5A5_0000;
    opcode_rb_operand_i = {rd, 27'h0} | 32'h0000_0777;
  endtask

  task automatic end_offer();
    opcode_valid_i   = 1'b0;
    opcode_invalid_i = 1'b0;
  endtask

  task automatic offer(input logic [31:0] op, input logic [4:0] rd, input logic inv);
    drive_offer(op, rd, inv);
    tick(1);
    end_offer();
  endtask

  task automatic result(input logic [31:0] value);
    conv_valid_i     = 1'b1;
    conv_writeback_i = value;
    tick(1);
    conv_valid_i     = 1'b0;
  endtask

  initial begin
    rst_i = 1; flush_i = 0; conv_busy_i = 0; conv_valid_i = 0; conv_writeback_i = '0;
    opcode_valid_i = 0; opcode_opcode_i = '0; opcode_pc_i = '0; opcode_invalid_i = 0;
    opcode_rd_idx_i = '0; opcode_ra_idx_i = '0; opcode_rb_idx_i = '0;
    opcode_ra_operand_i = '0; opcode_rb_operand_i = '0;
    tick(3);
    rst_i = 0;
    tick(5);
    chk("idle_opcode", conv_opcode_o, NOP);
    chk("idle_stall", stall_o, 0);
    chk("idle_wb_valid", wb_valid_o, 0);

    // Single instruction into an idle unit, then its result.
    drive_offer(32'h0000_000B, 5'd5, 1'b0);
`ifdef CONV_DISPATCH_BYPASS_EN
    #1;
    chk("bypass_opcode", conv_opcode_o, 32'h0000_000B);
    chk("bypass_rd", conv_rd_idx_o, 5);
    tick(1);
    end_offer();
    chk("bypass_one_cycle", conv_opcode_o, NOP);
`else
    tick(1);
    end_offer();
    chk("issue_not_early", conv_opcode_o, NOP);
    tick(1);
    chk("issue_opcode", conv_opcode_o, 32'h0000_000B);
    chk("issue_rd", conv_rd_idx_o, 5);
    tick(1);
    chk("issue_one_cycle", conv_opcode_o, NOP);
`endif
    result(32'h1234_5678);
    chk("wb_valid_lit", wb_valid_o, 1);
    chk("wb_rd_lit", wb_rd_idx_o, 5);
    chk("wb_value_lit", wb_value_o, 32'h1234_5678);
    tick(1);
    chk("wb_pulse", wb_valid_o, 0);

    // Fill while busy, overflow offer, then drain in order.
    conv_busy_i = 1;
    for (int i = 1; i <= 4; i++) offer(32'h0000_000B | (i << 12), 5'(i), 1'b0);
    chk("full_stall", stall_o, 1);
    offer(32'h0000_900B, 5'd9, 1'b0);
    chk("full_hold", stall_o, 1);
    conv_busy_i = 0;
    tick(1);
    chk("drain_first_rd", conv_rd_idx_o, 1);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      result(32'h0000_A000 + k);
      chk("drain_wb_rd", wb_rd_idx_o, 5'(k + 1));
      tick(1);
    end
    chk("drain_empty", stall_o, 0);

    // Non-custom and illegal offers are ignored.
    offer(32'h0000_0033, 5'd7, 1'b0);
    offer(32'h0000_000B, 5'd8, 1'b1);
    tick(3);
    chk("ignored_opcode", conv_opcode_o, NOP);

    // Flush with one in flight and three queued; a same-cycle offer is dropped.
    for (int i = 20; i <= 23; i++) offer(32'h0000_000B | (i << 12), 5'(i), 1'b0);
    drive_offer(32'h0001_800B, 5'd24, 1'b0);
    flush_i = 1;
    tick(1);
    flush_i = 0;
    end_offer();
    tick(2);
    result(32'h0000_BEEF);
    chk("flush_wb_rd", wb_rd_idx_o, 20);
    chk("flush_wb_value", wb_value_o, 32'h0000_BEEF);
    tick(4);
    chk("flush_no_dispatch", conv_opcode_o, NOP);

    // Stray result with nothing in flight.
    result(32'h0000_DEAD);
    chk("stray_wb", wb_valid_o, 0);

    // Reset mid-operation drops queued and in-flight work.
    conv_busy_i = 1;
    offer(32'h0000_300B, 5'd3, 1'b0);
    offer(32'h0000_400B, 5'd4, 1'b0);
    conv_busy_i = 0;
    tick(2);
    rst_i = 1;
    tick(1);
    rst_i = 0;
    result(32'h0000_0BAD);
    chk("reset_stray_wb", wb_valid_o, 0);
    tick(3);
    chk("reset_idle", conv_opcode_o, NOP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
